// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch stage.
package fetch_pkg;

    typedef enum logic [1:0] {
        S_REQ,
        S_WAIT,
        S_HOLD
    } fetch_state_t;

    localparam int          INSTR_BYTES      = 4;
    localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

endpackage

// File: rtl/fetch_unit_pc_next.sv
// Next-PC selection: sequential PC+4 or the word-aligned branch target.
module pc_next
    import fetch_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] pc_i,
    input  logic             pcsrc_i,
    input  logic [WIDTH-1:0] target_i,
    output logic [WIDTH-1:0] next_pc_o
);

    logic [WIDTH-1:0] seq_pc;
    logic [WIDTH-1:0] aligned_target;

    // Plain modular addition, so the last word of the space wraps to address 0.
    assign seq_pc         = pc_i + WIDTH'(INSTR_BYTES);
    assign aligned_target = {target_i[WIDTH-1:2], 2'b00};
    assign next_pc_o      = pcsrc_i ? aligned_target : seq_pc;

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage: owns the PC, issues one memory request at a time
// and holds the fetched word until the decode stage consumes it.
module fetch_unit
    import fetch_pkg::*;
#(
    parameter int               WIDTH    = 32,
    parameter logic [WIDTH-1:0] RESET_PC = WIDTH'(DEFAULT_RESET_PC),
    parameter int               COUNT_W  = 32
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               PCsrc,
    input  logic [WIDTH-1:0]   ImmTarget,
    output logic               imem_req,
    output logic [WIDTH-1:0]   imem_addr,
    input  logic               imem_gnt,
    input  logic               imem_rvalid,
    input  logic [31:0]        imem_rdata,
    output logic [31:0]        instr,
    output logic [WIDTH-1:0]   pc_out,
    output logic               instr_valid,
    input  logic               instr_ready,
    output logic [COUNT_W-1:0] fetch_count
);

    fetch_state_t       state_q, state_d;
    logic [WIDTH-1:0]   pc_q, pc_d;
    logic [WIDTH-1:0]   pc_out_q;
    logic [31:0]        instr_q;
    logic [COUNT_W-1:0] count_q;
    logic [WIDTH-1:0]   next_pc;
    logic               capture;
    logic               handoff;

    // Handshake inputs only matter in their own state, so stray gnt/rvalid are dropped.
    assign capture = (state_q == S_WAIT) && imem_rvalid;
    assign handoff = (state_q == S_HOLD) && instr_ready;

    pc_next #(
        .WIDTH(WIDTH)
    ) u_pc_next (
        .pc_i     (pc_q),
        .pcsrc_i  (PCsrc),
        .target_i (ImmTarget),
        .next_pc_o(next_pc)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_REQ;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_REQ:   if (imem_gnt)    state_d = S_WAIT;
            S_WAIT:  if (imem_rvalid) state_d = S_HOLD;
            S_HOLD:  if (instr_ready) state_d = S_REQ;
            default: state_d = S_REQ;
        endcase
    end

    always_comb begin
        imem_req    = 1'b0;
        instr_valid = 1'b0;
        case (state_q)
            S_REQ:   imem_req    = 1'b1;
            S_HOLD:  instr_valid = 1'b1;
            default: ;
        endcase
    end

    assign pc_d = handoff ? next_pc : pc_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_q     <= RESET_PC;
            pc_out_q <= '0;
            instr_q  <= '0;
            count_q  <= '0;
        end else begin
            pc_q <= pc_d;
            if (capture) begin
                instr_q  <= imem_rdata;
                pc_out_q <= pc_q;
            end
            if (handoff) begin
                count_q <= count_q + COUNT_W'(1);
            end
        end
    end

    assign imem_addr   = pc_q;
    assign instr       = instr_q;
    assign pc_out      = pc_out_q;
    assign fetch_count = count_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Directed plus randomized bench for fetch_unit; the expected PC stream is
// derived from the branch rules and the handed-off words from the bench memory.
module tb_fetch_unit;

    localparam int WIDTH   = 32;
    localparam int COUNT_W = 4;

    logic               clk = 1'b0;
    logic               rst_n = 1'b0;
    logic               PCsrc = 1'b0;
    logic [WIDTH-1:0]   ImmTarget = '0;
    logic               imem_req;
    logic [WIDTH-1:0]   imem_addr;
    logic               imem_gnt = 1'b0;
    logic               imem_rvalid = 1'b0;
    logic [31:0]        imem_rdata = '0;
    logic [31:0]        instr;
    logic [WIDTH-1:0]   pc_out;
    logic               instr_valid;
    logic               instr_ready = 1'b0;
    logic [COUNT_W-1:0] fetch_count;

    always #5 clk = ~clk;

    fetch_unit #(
        .WIDTH   (WIDTH),
        .RESET_PC(32'h0000_0000),
        .COUNT_W (COUNT_W)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .PCsrc      (PCsrc),
        .ImmTarget  (ImmTarget),
        .imem_req   (imem_req),
        .imem_addr  (imem_addr),
        .imem_gnt   (imem_gnt),
        .imem_rvalid(imem_rvalid),
        .imem_rdata (imem_rdata),
        .instr      (instr),
        .pc_out     (pc_out),
        .instr_valid(instr_valid),
        .instr_ready(instr_ready),
        .fetch_count(fetch_count)
    );

    int          checks = 0;
    int          errors = 0;
    logic [31:0] exp_pc;
    int          handoffs;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] exp_count();
        return 32'(handoffs % (1 << COUNT_W));
    endfunction

    // One complete fetch: request, optional grant stall, response wait, hold, handoff.
    task automatic fetch(input int gnt_dly, input int rv_dly, input int rdy_dly,
                         input logic br, input logic [31:0] tgt, input logic [31:0] word);
        $display("fetch pc=%h gnt_dly=%0d rv_dly=%0d rdy_dly=%0d br=%0b tgt=%h word=%h",
                 exp_pc, gnt_dly, rv_dly, rdy_dly, br, tgt, word);
        chk("req_start", 32'(imem_req), 32'd1);
        chk("addr_start", imem_addr, exp_pc);
        for (int i = 0; i < gnt_dly; i++) begin
            imem_rvalid = 1'($urandom_range(0, 1));
            imem_rdata  = $urandom;
            instr_ready = 1'($urandom_range(0, 1));
            tick;
            chk("req_held", 32'(imem_req), 32'd1);
            chk("addr_held", imem_addr, exp_pc);
            chk("valid_in_req", 32'(instr_valid), 32'd0);
        end
        imem_gnt    = 1'b1;
        imem_rvalid = 1'($urandom_range(0, 1));
        imem_rdata  = ~word;
        instr_ready = 1'b0;
        tick;
        imem_gnt    = 1'b0;
        imem_rvalid = 1'b0;
        chk("req_after_gnt", 32'(imem_req), 32'd0);
        chk("valid_after_gnt", 32'(instr_valid), 32'd0);
        for (int i = 0; i < rv_dly; i++) begin
            imem_gnt    = 1'($urandom_range(0, 1));
            instr_ready = 1'($urandom_range(0, 1));
            tick;
            chk("req_in_wait", 32'(imem_req), 32'd0);
            chk("valid_in_wait", 32'(instr_valid), 32'd0);
        end
        imem_gnt    = 1'b0;
        instr_ready = 1'b0;
        imem_rvalid = 1'b1;
        imem_rdata  = word;
        tick;
        imem_rvalid = 1'b0;
        imem_rdata  = $urandom;
        chk("valid_hold", 32'(instr_valid), 32'd1);
        chk("instr", instr, word);
        chk("pc_out", pc_out, exp_pc);
        chk("count_hold", 32'(fetch_count), exp_count());
        for (int i = 0; i < rdy_dly; i++) begin
            imem_gnt    = 1'($urandom_range(0, 1));
            imem_rvalid = 1'($urandom_range(0, 1));
            PCsrc       = 1'($urandom_range(0, 1));
            ImmTarget   = $urandom;
            tick;
            chk("stall_valid", 32'(instr_valid), 32'd1);
            chk("stall_instr", instr, word);
            chk("stall_pc_out", pc_out, exp_pc);
            chk("stall_req", 32'(imem_req), 32'd0);
            chk("stall_count", 32'(fetch_count), exp_count());
        end
        imem_gnt    = 1'b0;
        imem_rvalid = 1'b0;
        instr_ready = 1'b1;
        PCsrc       = br;
        ImmTarget   = tgt;
        tick;
        instr_ready = 1'b0;
        PCsrc       = 1'($urandom_range(0, 1));
        ImmTarget   = $urandom;
        exp_pc      = br ? (tgt & 32'hFFFF_FFFC) : exp_pc + 32'd4;
        handoffs++;
        chk("valid_after_handoff", 32'(instr_valid), 32'd0);
        chk("count_after_handoff", 32'(fetch_count), exp_count());
    endtask

    initial begin
        exp_pc   = 32'h0;
        handoffs = 0;
        tick;
        tick;
        chk("rst_instr", instr, 32'h0);
        chk("rst_valid", 32'(instr_valid), 32'd0);
        chk("rst_count", 32'(fetch_count), 32'd0);
        chk("rst_pc_out", pc_out, 32'h0);
        rst_n = 1'b1;

        fetch(0, 0, 0, 1'b0, 32'h0, 32'h0050_0093);
        fetch(3, 2, 0, 1'b1, 32'hDEAD_BEEF, $urandom);
        fetch(0, 0, 5, 1'b0, 32'h0, $urandom);
        fetch(1, 1, 1, 1'b0, 32'h0, $urandom);
        fetch(0, 0, 0, 1'b1, 32'h0000_0046, $urandom);
        fetch(0, 1, 0, 1'b1, 32'hFFFF_FFFF, $urandom);
        fetch(0, 0, 0, 1'b0, 32'h0, $urandom);
        chk("pc_wrap", imem_addr, 32'h0);

        for (int n = 0; n < 20; n++) begin
            fetch($urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3),
                  1'($urandom_range(0, 1)), $urandom, $urandom);
        end

        // Reset asserted while a response is outstanding.
        $display("reset during S_WAIT");
        imem_gnt = 1'b1;
        tick;
        imem_gnt = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        chk("mid_rst_instr", instr, 32'h0);
        chk("mid_rst_valid", 32'(instr_valid), 32'd0);
        chk("mid_rst_count", 32'(fetch_count), 32'd0);
        chk("mid_rst_pc_out", pc_out, 32'h0);
        tick;
        rst_n       = 1'b1;
        imem_rvalid = 1'b1;
        imem_rdata  = 32'hBAD0_BAD0;
        tick;
        imem_rvalid = 1'b0;
        chk("post_rst_valid", 32'(instr_valid), 32'd0);
        chk("post_rst_req", 32'(imem_req), 32'd1);
        chk("post_rst_addr", imem_addr, 32'h0);
        exp_pc   = 32'h0;
        handoffs = 0;
        fetch(0, 0, 0, 1'b0, 32'h0, $urandom);
        fetch(2, 0, 1, 1'b1, 32'h0000_1002, $urandom);
        fetch(0, 0, 0, 1'b0, 32'h0, $urandom);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
